// File: rtl/mau_pkg.sv
// Shared definitions for the MEM-stage memory access unit with posted store buffer.
// Holds func3 codes, the buffer FSM state type, the buffer entry layout and
// the lane alignment / extraction helpers used by the datapath.
package mau_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Width of the address field kept in each buffer entry.
  localparam int SB_ADDR_W = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } mau_state_t;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [31:0]          data;
    logic [3:0]           be;
  } sb_entry_t;

  // Byte enables for a store of the given width at the given byte lane.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
    logic [3:0] be;
    case (f3)
      F3_B:    be = 4'b0001 << lane;
      F3_H:    be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across lanes so the enabled lanes carry the value.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3)
      F3_B:    w = {4{d[7:0]}};
      F3_H:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Pick the addressed byte/half out of a cache word and extend it.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] rdata);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    shifted = rdata >> {lane, 3'b000};
    b       = shifted[7:0];
    h       = lane[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'd0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'd0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_unit_sb_fifo.sv
// sb_fifo: circular store buffer with a combinational word-address match
// across all currently valid entries.
module sb_fifo
  import mau_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  sb_entry_t            push_entry,
  input  logic                 pop,
  output sb_entry_t            head,
  output logic                 full,
  output logic                 empty,
  input  logic [SB_ADDR_W-1:0] match_addr,
  output logic                 match
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count;

  // Pointers, occupancy and valid flags; reset discards every buffered store.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      valid    <= '0;
    end else begin
      if (push) begin
        tail_ptr        <= tail_ptr + PTR_W'(1);
        valid[tail_ptr] <= 1'b1;
      end
      if (pop) begin
        head_ptr        <= head_ptr + PTR_W'(1);
        valid[head_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset because the valid flags gate every use.
  always_ff @(posedge clock) begin
    if (push) entries[tail_ptr] <= push_entry;
  end

  assign head  = entries[head_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Any valid entry targeting the same word forces a load to wait for draining.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i].addr == match_addr)) match = 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_unit_sb.sv
// mem_access_unit_sb: MEM-stage load/store unit with a posted store buffer
// drained to the data cache in the background, and a cache-select register
// that only changes once all posted stores have reached the cache.
// Optional misaligned-access trap: define MAU_MISALIGN_CHECK_EN.
module mem_access_unit_sb
  import mau_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int SB_DEPTH = 4,
  parameter int SEL_W    = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              wb_sel,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [31:0]       rs2_data,
  input  logic [2:0]        func3,
  input  logic [SEL_W-1:0]  cache_sel_value,
  input  logic              cache_sel_write,
  output logic              busywait,
  output logic [31:0]       wb_data,
  output logic              misalign,
  output logic [SEL_W-1:0]  cache_sel,
  output logic              c_read,
  output logic              c_write,
  output logic [ADDR_W-1:0] c_addr,
  output logic [31:0]       c_wdata,
  output logic [3:0]        c_byte_en,
  input  logic [31:0]       c_rdata,
  input  logic              c_busywait
);

  mau_state_t        state;
  mau_state_t        next_state;
  logic [ADDR_W-1:0] word_addr;
  logic [1:0]        lane;
  logic              misaligned;
  logic              load_req;
  logic              store_req;
  logic              load_go;
  logic              sel_ready;
  logic              sel_block;
  logic              push;
  logic              pop;
  sb_entry_t         push_entry;
  sb_entry_t         head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              addr_match;

  assign word_addr = {alu_result[ADDR_W-1:2], 2'b00};
  assign lane      = alu_result[1:0];

`ifdef MAU_MISALIGN_CHECK_EN
  // Flag half/word accesses whose low address bits do not fit the access size.
  always_comb begin
    misaligned = 1'b0;
    if (mem_read || mem_write) begin
      case (func3)
        F3_H, F3_HU: misaligned = lane[0];
        F3_W:        misaligned = (lane != 2'b00);
        default:     misaligned = 1'b0;
      endcase
    end
  end
  assign misalign = misaligned;
`else
  assign misaligned = 1'b0;
  assign misalign   = 1'b0;
`endif

  assign load_req  = mem_read && !misaligned;
  assign store_req = mem_write && !misaligned;
  assign load_go   = load_req && !addr_match;
  assign sel_ready = fifo_empty && (state == IDLE);
  assign sel_block = cache_sel_write && !sel_ready;

  assign push_entry = '{addr: SB_ADDR_W'(word_addr),
                        data: store_data(func3, rs2_data),
                        be:   store_be(func3, lane)};

  sb_fifo #(
    .DEPTH(SB_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .match_addr (SB_ADDR_W'(word_addr)),
    .match      (addr_match)
  );

  // Drain FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next state, cache requests, buffer push/pop and the pipeline stall.
  always_comb begin
    next_state = state;
    c_read     = 1'b0;
    c_write    = 1'b0;
    c_addr     = '0;
    c_wdata    = '0;
    c_byte_en  = '0;
    pop        = 1'b0;
    busywait   = 1'b0;
    push       = store_req && !fifo_full && !sel_block;

    case (state)
      IDLE: begin
        if (load_go) begin
          c_read = 1'b1;
          c_addr = word_addr;
        end else if (!fifo_empty) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        c_write   = 1'b1;
        c_addr    = ADDR_W'(head.addr);
        c_wdata   = head.data;
        c_byte_en = head.be;
        if (!c_busywait) begin
          pop        = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase

    if (load_req) begin
      if (addr_match) busywait = 1'b1;
      else            busywait = !((state == IDLE) && !c_busywait);
    end
    if (store_req && fifo_full) busywait = 1'b1;
    if (sel_block)              busywait = 1'b1;
  end

  // Cache-select register changes only with the buffer empty and idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                            cache_sel <= '0;
    else if (cache_sel_write && sel_ready) cache_sel <= cache_sel_value;
  end

  // Write-back mux between extracted load data and the ALU result.
  always_comb begin
    wb_data = wb_sel ? load_extract(func3, lane, c_rdata) : 32'(alu_result);
  end

endmodule

// File: tb/tb_mem_access_unit_sb.sv
// Testbench for mem_access_unit_sb: directed scenarios plus randomized
// load/store traffic, checked by a scoreboard against a byte-level memory model.
module tb_mem_access_unit_sb;
  import mau_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_read, mem_write, wb_sel, cache_sel_write;
  logic [31:0] alu_result, rs2_data;
  logic [2:0]  func3, cache_sel_value;
  logic        busywait, misalign, c_read, c_write, c_busywait;
  logic [31:0] wb_data, c_addr, c_wdata, c_rdata;
  logic [2:0]  cache_sel;
  logic [3:0]  c_byte_en;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } drain_t;

  drain_t      sb_q[$];
  logic [31:0] wb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          drains_seen = 0;
  int          busy_mode = 0;
  logic        instr_active = 1'b0;
  logic [31:0] cache_mem [1024];
  logic [7:0]  model_bytes [4096];

  mem_access_unit_sb #(.ADDR_W(32), .SB_DEPTH(4), .SEL_W(3)) dut (
    .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .wb_sel(wb_sel), .alu_result(alu_result), .rs2_data(rs2_data), .func3(func3),
    .cache_sel_value(cache_sel_value), .cache_sel_write(cache_sel_write),
    .busywait(busywait), .wb_data(wb_data), .misalign(misalign), .cache_sel(cache_sel),
    .c_read(c_read), .c_write(c_write), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_byte_en(c_byte_en), .c_rdata(c_rdata), .c_busywait(c_busywait)
  );

  always #5 clock = ~clock;

  always_comb c_rdata = cache_mem[c_addr[11:2]];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic int access_size(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3);
    int size, base;
    logic [31:0] val;
    size = access_size(f3);
    base = int'(addr[11:0]) & ~(size - 1);
    val  = 32'd0;
    for (int k = 0; k < size; k++) val = val | (32'(model_bytes[base + k]) << (8 * k));
    if (!f3[2] && size < 4 && val[8 * size - 1]) val = val | (32'hFFFF_FFFF << (8 * size));
    return val;
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] data);
    int size, base;
    drain_t d;
    size = access_size(f3);
    base = int'(addr[11:0]) & ~(size - 1);
    for (int k = 0; k < size; k++) model_bytes[base + k] = 8'(data >> (8 * k));
    d.addr = 32'(base & ~3);
    d.be   = 4'(((1 << size) - 1) << (base & 3));
    d.data = (size == 1) ? {4{data[7:0]}} : (size == 2) ? {2{data[15:0]}} : data;
    sb_q.push_back(d);
  endtask

  task automatic resync_model();
    for (int i = 0; i < 4096; i++) model_bytes[i] = 8'(cache_mem[i / 4] >> (8 * (i % 4)));
  endtask

  // kind: 1 = load, 2 = store, 3 = cache-select write, other = ALU op
  task automatic apply_stimulus(input int kind, input logic [31:0] addr, input logic [31:0] data,
                                input logic [2:0] f3, input logic [2:0] sv, output int stalls);
    logic [31:0] exp_wb;
    exp_wb = addr;
    if (kind == 1) exp_wb = model_load(addr, f3);
    if (kind == 2) model_store(addr, f3, data);
    wb_q.push_back(exp_wb);
    mem_read = (kind == 1); mem_write = (kind == 2); cache_sel_write = (kind == 3);
    wb_sel = (kind == 1); alu_result = addr; rs2_data = data; func3 = f3;
    cache_sel_value = sv; instr_active = 1'b1;
    stalls = 0;
    while (1) begin
      @(negedge clock);
      if (!busywait) break;
      stalls++;
      if (stalls > 1000) begin
        checks++; errors++;
        $display("[TB] FAIL accept_timeout: got busywait stuck %0d cycles, expected release", stalls);
        break;
      end
    end
    @(posedge clock); #1;
    mem_read = 0; mem_write = 0; cache_sel_write = 0; wb_sel = 0;
    instr_active = 1'b0;
  endtask

  task automatic wait_drained();
    int n;
    busy_mode = 2;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge clock);
      n++;
    end
    @(posedge clock); #1;
    check_output("drain_wait", sb_q.size(), 0);
  endtask

  // Cache busy generator: random, held busy, or held ready.
  initial begin
    c_busywait = 1'b0;
    forever begin
      @(posedge clock); #1;
      case (busy_mode)
        1:       c_busywait = 1'b1;
        2:       c_busywait = 1'b0;
        default: c_busywait = ($urandom_range(0, 2) == 0);
      endcase
    end
  end

  // Monitor: retiring instructions and completed cache writes against the scoreboard.
  initial begin
    drain_t d;
    logic [31:0] exp;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (instr_active && !busywait) begin
          if (wb_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL wb_underflow: got wb_data 0x%08h, expected none", wb_data);
          end else begin
            exp = wb_q.pop_front();
            check_output("wb_data", wb_data, exp);
          end
        end
        if (c_write && !c_busywait) begin
          drains_seen++;
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL drain_unexpected: got addr 0x%08h, expected no write", c_addr);
          end else begin
            d = sb_q.pop_front();
            check_output("drain_addr", c_addr, d.addr);
            check_output("drain_data", c_wdata, d.data);
            check_output("drain_be", {28'd0, c_byte_en}, {28'd0, d.be});
          end
          for (int k = 0; k < 4; k++)
            if (c_byte_en[k]) cache_mem[c_addr[11:2]][8 * k +: 8] = c_wdata[8 * k +: 8];
        end
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got no finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int st, r, d0, kind;
    logic [31:0] addr;
    logic [2:0]  f3;

    reset = 1'b0; mem_read = 0; mem_write = 0; wb_sel = 0; cache_sel_write = 0;
    alu_result = 0; rs2_data = 0; func3 = 0; cache_sel_value = 0;
    for (int i = 0; i < 1024; i++) cache_mem[i] = $urandom;
    resync_model();
    repeat (3) @(posedge clock);
    #1;
    check_output("rst_busywait", 32'(busywait), 0);
    check_output("rst_c_read", 32'(c_read), 0);
    check_output("rst_c_write", 32'(c_write), 0);
    check_output("rst_c_addr", c_addr, 0);
    check_output("rst_c_wdata", c_wdata, 0);
    check_output("rst_c_byte_en", 32'(c_byte_en), 0);
    check_output("rst_cache_sel", 32'(cache_sel), 0);
    check_output("rst_misalign", 32'(misalign), 0);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;

    $display("[TB] SB byte replication");
    busy_mode = 2;
    apply_stimulus(2, 32'h103, 32'h0000_00A5, F3_B, 0, st);
    check_output("sb_accept_stall", st, 0);
    wait_drained();

    $display("[TB] buffer full stall");
    busy_mode = 1;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(2, 32'h40 + 32'(4 * i), $urandom, F3_W, 0, st);
      check_output("fill_stall", st, 0);
    end
    fork
      begin repeat (6) @(posedge clock); busy_mode = 2; end
    join_none
    apply_stimulus(2, 32'h50, $urandom, F3_W, 0, st);
    check_output("full_stalls_ge5", 32'(st >= 5), 1);
    wait_drained();

    $display("[TB] load hazard and extension");
    busy_mode = 0;
    apply_stimulus(2, 32'h200, 32'h1234_5678, F3_W, 0, st);
    apply_stimulus(1, 32'h202, 0, F3_H, 0, st);
    check_output("hazard_stalled", 32'(st > 0), 1);
    wait_drained();
    cache_mem[32'h300 >> 2] = 32'h0000_0080;
    resync_model();
    apply_stimulus(1, 32'h300, 0, F3_B, 0, st);

    $display("[TB] cache select waits for drain");
    busy_mode = 1;
    check_output("sel_pre", 32'(cache_sel), 0);
    apply_stimulus(2, 32'h10, $urandom, F3_W, 0, st);
    apply_stimulus(2, 32'h14, $urandom, F3_W, 0, st);
    fork
      begin repeat (8) @(posedge clock); busy_mode = 2; end
    join_none
    apply_stimulus(3, 32'h0, 0, 0, 3'd5, st);
    check_output("sel_stalls_ge7", 32'(st >= 7), 1);
    check_output("sel_value", 32'(cache_sel), 5);
    check_output("sel_drained", sb_q.size(), 0);

    $display("[TB] reset during drain");
    wait_drained();
    busy_mode = 1;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(2, 32'h20 + 32'(4 * i), $urandom, F3_W, 0, st);
      check_output("pre_reset_stall", st, 0);
    end
    @(negedge clock);
    check_output("drain_active", 32'(c_write), 1);
    #2 reset = 1'b0;
    #1;
    check_output("reset_c_write", 32'(c_write), 0);
    check_output("reset_busywait", 32'(busywait), 0);
    sb_q.delete();
    resync_model();
    @(negedge clock);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    busy_mode = 2;
    check_output("reset_cache_sel", 32'(cache_sel), 0);
    d0 = drains_seen;
    repeat (5) @(posedge clock);
    #1;
    check_output("post_reset_drains", drains_seen - d0, 0);
    apply_stimulus(1, 32'h24, 0, F3_W, 0, st);
    check_output("post_reset_no_match", st, 0);

    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      if (n % 25 == 0) busy_mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
      r = $urandom_range(0, 9);
      kind = (r < 4) ? 1 : (r < 8) ? 2 : (r == 8) ? 0 : 9;
      case ($urandom_range(0, 4))
        0: f3 = F3_B;
        1: f3 = F3_H;
        2: f3 = F3_W;
        3: f3 = F3_BU;
        default: f3 = F3_HU;
      endcase
      if (kind == 2) f3 = 3'($urandom_range(0, 2));
      addr = 32'($urandom_range(0, 63));
`ifdef MAU_MISALIGN_CHECK_EN
      addr = addr & ~32'(access_size(f3) - 1);
`endif
      if (kind == 9) begin
        @(posedge clock); #1;
      end else begin
        apply_stimulus(kind, addr, $urandom, f3, 0, st);
      end
    end

`ifdef MAU_MISALIGN_CHECK_EN
    $display("[TB] misaligned word load");
    wait_drained();
    wb_q.push_back(32'h102);
    mem_read = 1; wb_sel = 0; func3 = F3_W; alu_result = 32'h102; instr_active = 1'b1;
    @(negedge clock);
    check_output("mis_flag", 32'(misalign), 1);
    check_output("mis_c_read", 32'(c_read), 0);
    check_output("mis_busywait", 32'(busywait), 0);
    @(posedge clock); #1;
    mem_read = 0; instr_active = 1'b0;
`endif

    wait_drained();
    check_output("wb_queue_empty", wb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
